seq_rom_scanner: RTL and testbench

Upstream stage of `taglist_gen`. It walks the sequence ROM from address 0, reads one word at a time and classifies each word into the 2-bit `lastEnd` code that `taglist_gen` consumes. `taglist_gen` counts plain words, closes a sequence entry on an end-of-sequence word, and finalises on end-of-ROM. The block also forwards each word's payload for later tag-matching stages.

---
 rtl/seq_rom_scanner_if.sv | 22 ++
 rtl/seq_rom_scanner.sv | 189 ++++++++++++++++++
 tb/tb_seq_rom_scanner.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_rom_scanner_if.sv
// ROM read port bundle for seq_rom_scanner: address/strobe out, data back.
// The scanner takes the master side; the ROM (or its model) takes the slave side.
interface seq_rom_scanner_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output rom_addr,
        output rom_en,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        input  rom_en,
        output rom_data
    );
endinterface

// File: rtl/seq_rom_scanner.sv
// Walks the sequence ROM from address 0 and classifies each word into the lastEnd code for taglist_gen.
// Optional even-parity check on each ROM word is enabled by defining SCAN_PARITY_EN.
module seq_rom_scanner #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned GUARD   = 1
) (
    input  logic                clk_1KHz,
    input  logic                reset_n,
    input  logic                start,
    seq_rom_scanner_if.master   rom,
    output logic [1:0]          lastEnd,
    output logic [DATA_W-3:0]   word_out,
    output logic                scan_busy,
    output logic                scan_done,
    output logic                overflow_err,
    output logic                parity_err
);

    localparam int unsigned CNT_MAX = (ROM_LAT > GUARD) ? ROM_LAT : GUARD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] CODE_PLAIN = 2'b00;
    localparam logic [1:0] CODE_NOP   = 2'b01;
    localparam logic [1:0] CODE_SEQ   = 2'b10;
    localparam logic [1:0] CODE_END   = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [CNT_W-1:0]  WAIT_LD   = CNT_W'(ROM_LAT - 1);
    localparam logic [CNT_W-1:0]  GUARD_LD  = CNT_W'(GUARD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_GUARD,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic                r_rom_en;
    logic [1:0]          r_last_end;
    logic [DATA_W-3:0]   r_word_out;
    logic                r_scan_busy;
    logic                r_scan_done;
    logic                r_overflow_err;
    logic                r_parity_err;

    logic                w_eos;
    logic                w_eor;
    logic                w_at_last;
    logic                w_par_bad;
    logic                w_ovf;
    logic [1:0]          w_code;

    assign w_eos     = rom.rom_data[DATA_W-1];
    assign w_eor     = rom.rom_data[DATA_W-2];
    assign w_at_last = (r_rom_addr == ADDR_LAST);

`ifdef SCAN_PARITY_EN
    assign w_par_bad = ^rom.rom_data;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_ovf = !w_par_bad && !w_eor && w_at_last;

    // Priority: parity failure, end-of-ROM, address exhaustion, end-of-sequence, plain.
    always_comb begin
        w_code = CODE_PLAIN;
        if (w_par_bad || w_eor || w_at_last) begin
            w_code = CODE_END;
        end else if (w_eos) begin
            w_code = CODE_SEQ;
        end
    end

    // The word is classified on the capture edge so the registered code is
    // valid for the whole EMIT cycle; EMIT then branches on that stored code.
    always_ff @(posedge clk_1KHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_rom_addr     <= '0;
            r_rom_en       <= 1'b0;
            r_last_end     <= CODE_NOP;
            r_word_out     <= '0;
            r_scan_busy    <= 1'b0;
            r_scan_done    <= 1'b0;
            r_overflow_err <= 1'b0;
            r_parity_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_FETCH;
                        r_rom_addr  <= '0;
                        r_rom_en    <= 1'b1;
                        r_scan_busy <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    r_rom_en <= 1'b0;
                    r_cnt    <= WAIT_LD;
                    r_state  <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_last_end <= w_code;
                        r_word_out <= rom.rom_data[DATA_W-3:0];
                        if (w_par_bad) begin
                            r_parity_err <= 1'b1;
                        end
                        if (w_ovf) begin
                            r_overflow_err <= 1'b1;
                        end
                        r_state <= ST_EMIT;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_EMIT: begin
                    case (r_last_end)
                        CODE_END: begin
                            r_scan_busy <= 1'b0;
                            r_scan_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                        CODE_SEQ: begin
                            r_last_end <= CODE_NOP;
                            r_cnt      <= GUARD_LD;
                            r_state    <= ST_GUARD;
                        end
                        default: begin
                            r_last_end <= CODE_NOP;
                            r_rom_addr <= r_rom_addr + ADDR_W'(1);
                            r_rom_en   <= 1'b1;
                            r_state    <= ST_FETCH;
                        end
                    endcase
                end

                ST_GUARD: begin
                    if (r_cnt == '0) begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        r_rom_en   <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    if (start) begin
                        r_scan_done    <= 1'b0;
                        r_overflow_err <= 1'b0;
                        r_parity_err   <= 1'b0;
                        r_last_end     <= CODE_NOP;
                        r_rom_addr     <= '0;
                        r_rom_en       <= 1'b1;
                        r_scan_busy    <= 1'b1;
                        r_state        <= ST_FETCH;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom.rom_addr  = r_rom_addr;
    assign rom.rom_en    = r_rom_en;
    assign lastEnd       = r_last_end;
    assign word_out      = r_word_out;
    assign scan_busy     = r_scan_busy;
    assign scan_done     = r_scan_done;
    assign overflow_err  = r_overflow_err;
    assign parity_err    = r_parity_err;

endmodule

// File: tb/tb_seq_rom_scanner.sv
// Scoreboard bench for seq_rom_scanner: a ROM-walk reference model queues expected codes,
// a negedge monitor pops and compares each emitted word.
module tb_seq_rom_scanner;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int ROM_LAT = 1;
    localparam int GUARD   = 1;
    localparam int NWORDS  = 1 << ADDR_W;

`ifdef SCAN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk_1KHz = 1'b0;
    logic              reset_n  = 1'b0;
    logic              start    = 1'b0;
    logic [1:0]        lastEnd;
    logic [DATA_W-3:0] word_out;
    logic              scan_busy;
    logic              scan_done;
    logic              overflow_err;
    logic              parity_err;

    seq_rom_scanner_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rom_if ();

    seq_rom_scanner #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ROM_LAT(ROM_LAT),
        .GUARD  (GUARD)
    ) dut (
        .clk_1KHz    (clk_1KHz),
        .reset_n     (reset_n),
        .start       (start),
        .rom         (rom_if),
        .lastEnd     (lastEnd),
        .word_out    (word_out),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .overflow_err(overflow_err),
        .parity_err  (parity_err)
    );

    always #5 clk_1KHz = ~clk_1KHz;

    // ROM model: data appears ROM_LAT cycles after the strobe, garbage otherwise.
    logic [DATA_W-1:0] mem  [NWORDS];
    logic [DATA_W-1:0] pipe [ROM_LAT];

    always @(posedge clk_1KHz) begin
        if (rom_if.rom_en) pipe[0] <= mem[rom_if.rom_addr];
        else               pipe[0] <= $urandom;
        for (int i = 1; i < ROM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_if.rom_data = pipe[ROM_LAT-1];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]        code;
        logic [DATA_W-3:0] payload;
        logic [ADDR_W-1:0] addr;
        int                gap;
    } exp_t;

    exp_t              sbq[$];
    logic              exp_ovf;
    logic              exp_par;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-3:0] exp_word;

    // Reference: walk the ROM applying the classification rules word by word.
    task automatic model_scan();
        int a = 0;
        int gap = -1;
        logic [DATA_W-1:0] w;
        exp_t e;
        exp_ovf = 1'b0;
        exp_par = 1'b0;
        while (1) begin
            w = mem[a];
            e.addr = ADDR_W'(a);
            e.payload = w[DATA_W-3:0];
            e.gap = gap;
            if (PAR_EN && (^w)) begin
                e.code = 2'b11; exp_par = 1'b1; sbq.push_back(e); break;
            end else if (w[DATA_W-2]) begin
                e.code = 2'b11; sbq.push_back(e); break;
            end else if (a == NWORDS - 1) begin
                e.code = 2'b11; exp_ovf = 1'b1; sbq.push_back(e); break;
            end else if (w[DATA_W-1]) begin
                e.code = 2'b10; sbq.push_back(e); gap = ROM_LAT + 1 + GUARD;
            end else begin
                e.code = 2'b00; sbq.push_back(e); gap = ROM_LAT + 1;
            end
            a++;
        end
        exp_addr = ADDR_W'(a);
        exp_word = w[DATA_W-3:0];
    endtask

    // Monitor: each non-01 code must be preceded by a 01 cycle, except DONE holding 11.
    logic [1:0] prev_le = 2'b01;
    int         nop_run = 0;

    always @(negedge clk_1KHz) begin
        exp_t e;
        if (lastEnd != 2'b01 && prev_le == 2'b01) begin
            if (sbq.size() == 0) begin
                chk("unexpected_emit", {62'd0, lastEnd}, 64'h1);
            end else begin
                e = sbq.pop_front();
                chk("code", {62'd0, lastEnd}, {62'd0, e.code});
                chk("payload", 64'(word_out), 64'(e.payload));
                chk("emit_addr", 64'(rom_if.rom_addr), 64'(e.addr));
                if (e.gap >= 0) chk("nop_gap", 64'(nop_run), 64'(e.gap));
            end
            nop_run = 0;
        end else if (lastEnd == 2'b01) begin
            nop_run++;
        end else begin
            chk("code_hold", {60'd0, prev_le, lastEnd}, 64'hF);
        end
        prev_le = lastEnd;
    end

    function automatic logic [DATA_W-1:0] fixp(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r = w;
        if (^r) r[0] = ~r[0];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] mkword(input bit eos, input bit eor);
        logic [DATA_W-1:0] r = $urandom;
        r[DATA_W-1] = eos;
        r[DATA_W-2] = eor;
        return fixp(r);
    endfunction

    task automatic run_scan(input bit pulse_mid, output int cycles);
        model_scan();
        @(negedge clk_1KHz) start = 1'b1;
        @(negedge clk_1KHz) start = 1'b0;
        chk("start_busy", 64'(scan_busy), 64'h1);
        chk("start_done_clr", 64'(scan_done), 64'h0);
        chk("start_errs_clr", {62'd0, overflow_err, parity_err}, 64'h0);
        chk("start_rom_en", 64'(rom_if.rom_en), 64'h1);
        chk("start_addr", 64'(rom_if.rom_addr), 64'h0);
        cycles = 0;
        if (pulse_mid) begin
            @(negedge clk_1KHz) start = 1'b1;
            cycles++;
            @(negedge clk_1KHz) start = 1'b0;
            cycles++;
        end
        while (!scan_done && cycles < 8000) begin
            @(negedge clk_1KHz);
            cycles++;
        end
        chk("done_reached", 64'(scan_done), 64'h1);
        @(negedge clk_1KHz);
        chk("done_busy", 64'(scan_busy), 64'h0);
        chk("done_code", {62'd0, lastEnd}, 64'h3);
        chk("done_addr", 64'(rom_if.rom_addr), 64'(exp_addr));
        chk("done_word", 64'(word_out), 64'(exp_word));
        chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
        chk("parity_err", 64'(parity_err), 64'(exp_par));
        chk("sb_empty", 64'(sbq.size()), 64'h0);
        sbq.delete();
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < NWORDS; i++) mem[i] = mkword(1'b0, 1'b0);

        // Reset and idle behaviour
        reset_n = 1'b0;
        repeat (3) @(posedge clk_1KHz);
        @(negedge clk_1KHz) reset_n = 1'b1;
        chk("rst_addr", 64'(rom_if.rom_addr), 64'h0);
        chk("rst_word", 64'(word_out), 64'h0);
        chk("rst_flags", {60'd0, scan_done, overflow_err, parity_err, scan_busy}, 64'h0);
        repeat (5) begin
            @(negedge clk_1KHz);
            chk("idle_code", {62'd0, lastEnd}, 64'h1);
            chk("idle_rom_en", 64'(rom_if.rom_en), 64'h0);
            chk("idle_busy", 64'(scan_busy), 64'h0);
        end

        // plain, plain, seq-end, end-of-ROM
        mem[0] = mkword(1'b0, 1'b0);
        mem[1] = mkword(1'b0, 1'b0);
        mem[2] = mkword(1'b1, 1'b0);
        mem[3] = mkword(1'b0, 1'b1);
        run_scan(1'b0, cyc);

        // Both flags on word 0: end-of-ROM wins, DONE three cycles after FETCH
        mem[0] = mkword(1'b1, 1'b1);
        run_scan(1'b0, cyc);
        chk("both_flags_cycles", 64'(cyc), 64'd3);

        // Randomised ROM contents, with a start pulse during the first WAIT
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem[i] = mkword($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
                if ($urandom_range(0, 9) == 0) mem[i][0] = ~mem[i][0];
            end
            run_scan(s[0], cyc);
        end

        // No end-of-ROM anywhere: address space exhausted
        for (int i = 0; i < NWORDS; i++) mem[i] = mkword($urandom_range(0, 3) == 0, 1'b0);
        run_scan(1'b0, cyc);

        // Odd parity on word 1
        for (int i = 0; i < NWORDS; i++) mem[i] = mkword(1'b0, 1'b0);
        mem[1][0] = ~mem[1][0];
        mem[5] = mkword(1'b0, 1'b1);
        run_scan(1'b0, cyc);

        // start in WAIT is ignored, then reset lands in EMIT
        mem[0] = mkword(1'b0, 1'b0);
        @(negedge clk_1KHz) start = 1'b1;
        @(negedge clk_1KHz) start = 1'b0;
        @(negedge clk_1KHz) start = 1'b1;
        @(posedge clk_1KHz) #1;
        start = 1'b0;
        chk("emit_before_rst", {62'd0, lastEnd}, 64'h0);
        reset_n = 1'b0;
        #1;
        chk("async_rst_code", {62'd0, lastEnd}, 64'h1);
        chk("async_rst_word", 64'(word_out), 64'h0);
        chk("async_rst_flags", {59'd0, rom_if.rom_en, scan_busy, scan_done, overflow_err, parity_err}, 64'h0);
        @(negedge clk_1KHz) reset_n = 1'b1;
        repeat (3) @(negedge clk_1KHz);
        chk("post_rst_idle", {61'd0, lastEnd, rom_if.rom_en}, 64'h2);

        mem[2] = mkword(1'b0, 1'b1);
        run_scan(1'b0, cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
